fetch_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_out_buf.sv | 40 ++++
 rtl/fetch_stage.sv | 147 ++++++++++++++
 tb/tb_fetch_stage.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
    localparam int LINE_WORDS = 4;
    localparam int WORD_W     = 64;
    localparam int ADDR_W     = 64;

    typedef enum logic [2:0] {
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        FILL,
        SETTLE
    } fetch_state_e;

    // Index of the lowest clear bit; 0 when the mask is all ones (callers only use it on a miss).
    function automatic logic [1:0] lowest_zero(input logic [LINE_WORDS-1:0] mask);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = LINE_WORDS - 1; i >= 0; i--) begin
            if (!mask[i]) idx = 2'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/fetch_out_buf.sv
// Single-entry valid/ready output register holding one fetch packet; flush empties it.
module fetch_out_buf
    import fetch_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [ADDR_W-1:0]            in_pc,
    input  logic [LINE_WORDS*WORD_W-1:0] in_data,
    input  logic [LINE_WORDS*WORD_W-1:0] in_len,
    output logic                         in_ready,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [ADDR_W-1:0]            out_pc,
    output logic [LINE_WORDS*WORD_W-1:0] out_data,
    output logic [LINE_WORDS*WORD_W-1:0] out_len
);
    // Slot can take a new packet when empty or when the current one leaves this cycle.
    assign in_ready = !out_valid || out_ready;

    // Packet register: flush has priority, then capture, then drain on acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_data  <= '0;
            out_len   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            out_data  <= in_data;
            out_len   <= in_len;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: drives I-cache lookups, emits 4-word packets, refills missing words from L2.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic [ADDR_W-1:0]            ic_addr,
    input  logic [LINE_WORDS*WORD_W-1:0] ic_data,
    input  logic [LINE_WORDS*WORD_W-1:0] ic_len_tag,
    input  logic [LINE_WORDS-1:0]        ic_hit,
    output logic                         l2_req_valid,
    output logic [ADDR_W-1:0]            l2_req_addr,
    input  logic                         l2_req_ready,
    input  logic                         l2_rsp_valid,
    input  logic [WORD_W-1:0]            l2_rsp_data,
    output logic                         fill_start,
    output logic [ADDR_W-1:0]            fill_addr,
    output logic [WORD_W-1:0]            fill_data,
    output logic                         fetch_valid,
    input  logic                         fetch_ready,
    output logic [ADDR_W-1:0]            fetch_pc,
    output logic [LINE_WORDS*WORD_W-1:0] fetch_data,
    output logic [LINE_WORDS*WORD_W-1:0] fetch_len,
    output logic [31:0]                  miss_cnt
);
    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [1:0]        miss_idx, miss_idx_nxt;
    logic              pend_v, pend_v_nxt;
    logic [ADDR_W-1:0] pend_pc, pend_pc_nxt;
    logic              cap;
    logic              buf_ready;
    logic [ADDR_W-1:0] miss_addr;

    assign ic_addr     = pc;
    assign miss_addr   = pc + ADDR_W'(miss_idx);
    assign l2_req_addr = miss_addr;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOOKUP;
        else       state <= state_nxt;
    end

    // Next-state and strobes. A redirect during an L2 transaction is parked as pending
    // so the in-flight word still lands in the cache.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        miss_idx_nxt = miss_idx;
        pend_v_nxt   = pend_v;
        pend_pc_nxt  = pend_pc;
        cap          = 1'b0;
        l2_req_valid = 1'b0;
        fill_start   = 1'b0;
        case (state)
            LOOKUP: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_pc;
                end else if (ic_hit == '1) begin
                    if (buf_ready) begin
                        cap    = 1'b1;
                        pc_nxt = pc + 64'd4;
                    end
                end else begin
                    miss_idx_nxt = lowest_zero(ic_hit);
                    state_nxt    = MISS_REQ;
                end
            end
            MISS_REQ: begin
                // Request is withdrawn in the redirect cycle so L2 never sees an orphan.
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = LOOKUP;
                end else begin
                    l2_req_valid = 1'b1;
                    if (l2_req_ready) state_nxt = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (redirect_valid) begin
                    pend_v_nxt  = 1'b1;
                    pend_pc_nxt = redirect_pc;
                end
                if (l2_rsp_valid) state_nxt = FILL;
            end
            FILL: begin
                fill_start = 1'b1;
                if (redirect_valid) begin
                    pend_v_nxt  = 1'b1;
                    pend_pc_nxt = redirect_pc;
                end
                state_nxt = SETTLE;
            end
            SETTLE: begin
                state_nxt  = LOOKUP;
                pend_v_nxt = 1'b0;
                if (redirect_valid) pc_nxt = redirect_pc;
                else if (pend_v)    pc_nxt = pend_pc;
            end
            default: state_nxt = LOOKUP;
        endcase
    end

    // Datapath registers: pc, miss bookkeeping, refill word and miss counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            miss_idx  <= 2'd0;
            pend_v    <= 1'b0;
            pend_pc   <= '0;
            fill_addr <= '0;
            fill_data <= '0;
            miss_cnt  <= '0;
        end else begin
            pc       <= pc_nxt;
            miss_idx <= miss_idx_nxt;
            pend_v   <= pend_v_nxt;
            pend_pc  <= pend_pc_nxt;
            if (state == MISS_WAIT && l2_rsp_valid) begin
                fill_addr <= miss_addr;
                fill_data <= l2_rsp_data;
            end
            if (state == FILL) miss_cnt <= miss_cnt + 32'd1;
        end
    end

    fetch_out_buf u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .in_valid  (cap),
        .in_pc     (pc),
        .in_data   (ic_data),
        .in_len    (ic_len_tag),
        .in_ready  (buf_ready),
        .out_ready (fetch_ready),
        .out_valid (fetch_valid),
        .out_pc    (fetch_pc),
        .out_data  (fetch_data),
        .out_len   (fetch_len)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural I-cache + L2 models and a packet-stream reference.
module tb_fetch_stage;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         redirect_valid = 1'b0;
    logic [63:0]  redirect_pc = '0;
    logic [63:0]  ic_addr;
    logic [255:0] ic_data, ic_len_tag;
    logic [3:0]   ic_hit;
    logic         l2_req_valid;
    logic [63:0]  l2_req_addr;
    logic         l2_req_ready = 1'b1;
    logic         l2_rsp_valid = 1'b0;
    logic [63:0]  l2_rsp_data = '0;
    logic         fill_start;
    logic [63:0]  fill_addr, fill_data;
    logic         fetch_valid;
    logic         fetch_ready = 1'b1;
    logic [63:0]  fetch_pc;
    logic [255:0] fetch_data, fetch_len;
    logic [31:0]  miss_cnt;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(64'h100)) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ic_addr(ic_addr), .ic_data(ic_data), .ic_len_tag(ic_len_tag), .ic_hit(ic_hit),
        .l2_req_valid(l2_req_valid), .l2_req_addr(l2_req_addr), .l2_req_ready(l2_req_ready),
        .l2_rsp_valid(l2_rsp_valid), .l2_rsp_data(l2_rsp_data),
        .fill_start(fill_start), .fill_addr(fill_addr), .fill_data(fill_data),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
        .fetch_data(fetch_data), .fetch_len(fetch_len), .miss_cnt(miss_cnt)
    );

    // Cache contents: presence per word (indexed by low address bits); data is a pure
    // function of the full address, so a refill just sets presence.
    bit present [0:4095];

    function automatic logic [63:0] word_of(input logic [63:0] a);
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
    endfunction
    function automatic logic [63:0] len_of(input logic [63:0] a);
        return {a[31:0], ~a[63:32]} ^ 64'h00F0_0F00_F00F_0FF0;
    endfunction
    function automatic logic [255:0] pack_data(input logic [63:0] p);
        logic [255:0] r;
        for (int d = 0; d < 4; d++) r[64*d +: 64] = word_of(p + 64'(d));
        return r;
    endfunction
    function automatic logic [255:0] pack_len(input logic [63:0] p);
        logic [255:0] r;
        for (int d = 0; d < 4; d++) r[64*d +: 64] = len_of(p + 64'(d));
        return r;
    endfunction
    function automatic logic [63:0] lowest_absent(input logic [63:0] p);
        logic [63:0] r;
        r = p;
        for (int d = 3; d >= 0; d--) if (!present[12'(p + 64'(d))]) r = p + 64'(d);
        return r;
    endfunction
    function automatic bit is_present(input logic [63:0] a);
        return present[12'(a)];
    endfunction

    // Combinational I-cache lookup; missing words return junk.
    always_comb begin
        ic_hit = '0;
        ic_data = '0;
        ic_len_tag = '0;
        for (int d = 0; d < 4; d++) begin
            ic_hit[d] = is_present(ic_addr + 64'(d));
            ic_data[64*d +: 64]    = ic_hit[d] ? word_of(ic_addr + 64'(d)) : 64'hBAD0_BAD0_BAD0_BAD0;
            ic_len_tag[64*d +: 64] = ic_hit[d] ? len_of(ic_addr + 64'(d))  : 64'hBAD1_BAD1_BAD1_BAD1;
        end
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus knobs and reference-model state.
    bit          rand_mode = 0, drv_ready = 1, drv_rd = 0;
    logic [63:0] drv_rd_pc = '0;
    int          l2_lat = 3, cyc = 0, l2_due = 0;
    logic [63:0] l2_q[$];
    logic [63:0] fill_log[$];
    logic [63:0] exp_pc = 64'h100, last_pc = '0, last_rsp_addr = '0;
    int          pkts = 0, fills = 0, reqs = 0;
    bit          p_rd = 0, p_hold = 0, p_req_wait = 0, p_fill = 0;
    logic [63:0] p_pc = '0, p_req_addr = '0;
    logic [255:0] p_data = '0;

    // Observe one cycle (called at the falling edge, before the next rising edge acts).
    task automatic monitor();
        if (p_rd) chk("flush_after_redirect", fetch_valid, 1'b0);
        if (p_hold) begin
            chk("hold_valid", fetch_valid, 1'b1);
            chk("hold_pc", fetch_pc, p_pc);
            chk("hold_data", fetch_data, p_data);
        end
        if (redirect_valid) begin
            exp_pc = redirect_pc;
        end else if (fetch_valid && fetch_ready) begin
            chk("pkt_pc", fetch_pc, exp_pc);
            chk("pkt_data", fetch_data, pack_data(exp_pc));
            chk("pkt_len", fetch_len, pack_len(exp_pc));
            last_pc = fetch_pc;
            exp_pc  = exp_pc + 64'd4;
            pkts++;
        end
        if (p_req_wait && !redirect_valid) begin
            chk("req_hold_valid", l2_req_valid, 1'b1);
            chk("req_hold_addr", l2_req_addr, p_req_addr);
        end
        if (l2_req_valid && l2_req_ready) begin
            chk("req_addr", l2_req_addr, lowest_absent(ic_addr));
            l2_q.push_back(l2_req_addr);
            l2_due = cyc + (rand_mode ? int'($urandom_range(1, 6)) : l2_lat);
            reqs++;
        end
        if (p_fill) chk("fill_one_cycle", fill_start, 1'b0);
        if (fill_start) begin
            chk("fill_addr", fill_addr, last_rsp_addr);
            chk("fill_data", fill_data, word_of(fill_addr));
            chk("miss_cnt_run", miss_cnt, fills);
            fills++;
            present[12'(fill_addr)] = 1'b1;
            fill_log.push_back(fill_addr);
        end
        p_rd       = redirect_valid;
        p_hold     = fetch_valid && !fetch_ready && !redirect_valid;
        p_pc       = fetch_pc;
        p_data     = fetch_data;
        p_req_wait = l2_req_valid && !l2_req_ready;
        p_req_addr = l2_req_addr;
        p_fill     = fill_start;
    endtask

    // One clock: drive inputs just after the rising edge, observe at the falling edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        fetch_ready    = rand_mode ? ($urandom_range(0, 3) != 0) : drv_ready;
        l2_req_ready   = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        redirect_valid = drv_rd;
        redirect_pc    = drv_rd_pc;
        drv_rd         = 0;
        if (rand_mode && $urandom_range(0, 40) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = 64'h600 + 64'($urandom_range(0, 'h1C0));
        end
        l2_rsp_valid = 1'b0;
        l2_rsp_data  = {$urandom, $urandom};
        if (l2_q.size() > 0) begin
            if (cyc >= l2_due) begin
                l2_rsp_valid  = 1'b1;
                last_rsp_addr = l2_q.pop_front();
                l2_rsp_data   = word_of(last_rsp_addr);
            end
        end else if ($urandom_range(0, 7) == 0) begin
            l2_rsp_valid = 1'b1;  // stray beat outside MISS_WAIT must be ignored
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic wait_pkts(input int target, input int budget);
        int n = 0;
        while (pkts < target && n < budget) begin cycle(); n++; end
        chk("wait_pkt_timeout", pkts >= target, 1'b1);
    endtask
    task automatic wait_fills(input int target, input int budget);
        int n = 0;
        while (fills < target && n < budget) begin cycle(); n++; end
        chk("wait_fill_timeout", fills >= target, 1'b1);
    endtask
    task automatic wait_reqs(input int target, input int budget);
        int n = 0;
        while (reqs < target && n < budget) begin cycle(); n++; end
        chk("wait_req_timeout", reqs >= target, 1'b1);
    endtask
    task automatic set_range(input int lo, input int hi, input bit v);
        for (int a = lo; a <= hi; a++) present[a] = v;
    endtask

    initial begin
        int b_pk, b_rq;
        logic [63:0] h_ic;
        set_range('h100, 'h5FF, 1'b1);
        set_range('h200, 'h3FF, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ic_addr", ic_addr, 64'h100);
        chk("rst_l2_addr", l2_req_addr, 64'h100);
        chk("rst_fetch_valid", fetch_valid, 1'b0);
        chk("rst_l2_valid", l2_req_valid, 1'b0);
        chk("rst_fill_start", fill_start, 1'b0);
        chk("rst_fetch_pc", fetch_pc, 64'h0);
        chk("rst_fetch_data", fetch_data, 256'h0);
        chk("rst_fetch_len", fetch_len, 256'h0);
        chk("rst_fill_addr", fill_addr, 64'h0);
        chk("rst_fill_data", fill_data, 64'h0);
        chk("rst_miss_cnt", miss_cnt, 32'h0);
        reset = 1'b0;

        // All-hit stream from the reset PC: one packet per cycle.
        repeat (3) cycle();
        chk("t1_pkts", pkts, 3);
        chk("t1_last_pc", last_pc, 64'h108);
        chk("t1_miss_cnt", miss_cnt, 32'h0);

        // Redirect in the same cycle as a full hit with ready high.
        drv_rd = 1; drv_rd_pc = 64'h500;
        b_pk = pkts;
        cycle();
        chk("t6_no_old_pkt", pkts, b_pk);
        repeat (2) cycle();
        chk("t6_pc", last_pc, 64'h500);

        // Back-pressure: packet held, pc frozen, no duplicate.
        drv_ready = 0;
        cycle();
        h_ic = ic_addr; b_pk = pkts;
        repeat (5) cycle();
        chk("t4_ic_addr", ic_addr, h_ic);
        chk("t4_pkts", pkts, b_pk);
        drv_ready = 1;
        cycle();
        chk("t4_one_pkt", pkts, b_pk + 1);
        drv_ready = 0;
        cycle();

        // Single missing word at 0x202.
        set_range('h200, 'h2FF, 1'b1);
        present['h202] = 1'b0;
        fill_log.delete();
        b_pk = pkts; b_rq = reqs;
        drv_rd = 1; drv_rd_pc = 64'h200; drv_ready = 1;
        wait_pkts(b_pk + 1, 40);
        chk("t2_pc", last_pc, 64'h200);
        chk("t2_reqs", reqs - b_rq, 1);
        chk("t2_fill_n", fill_log.size(), 1);
        if (fill_log.size() > 0) chk("t2_fill_addr", fill_log[0], 64'h202);
        chk("t2_miss_cnt", miss_cnt, 32'd1);
        drv_ready = 0;
        cycle();

        // Whole line missing: four refills in ascending order.
        set_range('h200, 'h203, 1'b0);
        fill_log.delete();
        b_pk = pkts;
        drv_rd = 1; drv_rd_pc = 64'h200; drv_ready = 1;
        wait_pkts(b_pk + 1, 80);
        chk("t3_pc", last_pc, 64'h200);
        chk("t3_fill_n", fill_log.size(), 4);
        for (int i = 0; i < 4 && i < fill_log.size(); i++) chk("t3_fill_order", fill_log[i], 64'h200 + 64'(i));
        chk("t3_miss_cnt", miss_cnt, 32'd5);
        drv_ready = 0;
        cycle();

        // Redirect while waiting on L2 for 0x202.
        present['h202] = 1'b0;
        fill_log.delete();
        b_rq = reqs;
        drv_rd = 1; drv_rd_pc = 64'h1FC;
        wait_reqs(b_rq + 1, 20);
        chk("t5_req_addr", p_req_addr == 64'h202 || l2_q.size() > 0, 1'b1);
        if (l2_q.size() > 0) chk("t5_req_is_202", l2_q[0], 64'h202);
        chk("t5_valid_before", fetch_valid, 1'b1);
        drv_rd = 1; drv_rd_pc = 64'h400;
        cycle();
        cycle();
        chk("t5_drop", fetch_valid, 1'b0);
        wait_fills(fills + 1, 20);
        if (fill_log.size() > 0) chk("t5_fill_addr", fill_log[0], 64'h202);
        cycle();
        cycle();
        chk("t5_ic_addr", ic_addr, 64'h400);
        b_pk = pkts; drv_ready = 1;
        wait_pkts(b_pk + 1, 10);
        chk("t5_pc", last_pc, 64'h400);
        drv_ready = 0;
        cycle();

        // Address wrap: line straddles 2^64, missing word sits past the wrap.
        set_range('hFFE, 'hFFF, 1'b1);
        set_range('h000, 'h00F, 1'b1);
        present['h001] = 1'b0;
        fill_log.delete();
        b_pk = pkts;
        drv_rd = 1; drv_rd_pc = 64'hFFFF_FFFF_FFFF_FFFE; drv_ready = 1;
        wait_pkts(b_pk + 2, 60);
        chk("wrap_pc", last_pc, 64'h2);
        if (fill_log.size() > 0) chk("wrap_fill_addr", fill_log[0], 64'h1);
        drv_ready = 0;
        cycle();

        // Randomized traffic over a partially populated region.
        for (int a = 'h600; a < 'h800; a++) present[a] = ($urandom_range(0, 9) < 7);
        drv_rd = 1; drv_rd_pc = 64'h600;
        cycle();
        b_pk = pkts;
        rand_mode = 1;
        repeat (1500) cycle();
        rand_mode = 0; drv_ready = 0;
        repeat (30) cycle();
        chk("rand_progress", pkts > b_pk + 50, 1'b1);
        chk("final_miss_cnt", miss_cnt, fills);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
